// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1:N stream demultiplexer.
// Imported by demux_slot and stream_demux_n.
package stream_demux_pkg;

  localparam int MODE_SEL   = 0;
  localparam int MODE_RR    = 1;
  localparam int DROP_CNT_W = 8;

  function automatic logic chan_ok(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake.
// A load in the same cycle as a drain wins, which keeps a channel at one beat per cycle.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      // data is left in place so the lane keeps showing its last beat
      valid <= 1'b0;
    end
  end

  always_comb can_accept = !valid || ready;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1:N valid/ready demultiplexer, routing by explicit select or round-robin.
// Out-of-range selects are consumed, dropped, flagged and counted.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [N*WIDTH-1:0]    out_data,
  output logic                  err_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int SLOTS = 2 ** SEL_W;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] target;
  logic             in_range;
  logic             accept;
  logic [N-1:0]     can_accept;
  logic [N-1:0]     load;
  logic [SLOTS-1:0] can_accept_pad;

  always_comb target = (MODE == MODE_RR) ? rr_ptr : in_sel;

  always_comb in_range = chan_ok(32'(target), N);

  // pad so every select code indexes a defined bit, even when N < 2**SEL_W
  always_comb begin
    can_accept_pad         = '0;
    can_accept_pad[N-1:0]  = can_accept;
  end

  always_comb in_ready = in_range ? can_accept_pad[target] : 1'b1;

  always_comb accept = in_valid && in_ready;

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k] = accept && in_range && (target == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .load_data  (in_data),
      .ready      (out_ready[k]),
      .valid      (out_valid[k]),
      .data       (out_data[k*WIDTH +: WIDTH]),
      .can_accept (can_accept[k])
    );
  end

  // strict order: the pointer only moves on an accepted beat, never skips a stalled lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((MODE == MODE_RR) && accept) begin
      rr_ptr <= (rr_ptr == SEL_W'(N - 1)) ? '0 : rr_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      err_pulse <= accept && !in_range;
      if (accept && !in_range && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n: select routing (N=4), out-of-range drops (N=3)
// and round-robin routing (N=4), all sharing one clock and reset.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: MODE=0, N=4
  logic        a_in_valid, a_in_ready, a_err;
  logic [7:0]  a_in_data, a_drop;
  logic [1:0]  a_in_sel;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  // b: MODE=0, N=3
  logic        b_in_valid, b_in_ready, b_err;
  logic [7:0]  b_in_data, b_drop;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;
  // c: MODE=1, N=4
  logic        c_in_valid, c_in_ready, c_err;
  logic [7:0]  c_in_data, c_drop;
  logic [1:0]  c_in_sel;
  logic [3:0]  c_out_valid, c_out_ready;
  logic [31:0] c_out_data;

  stream_demux_n #(.WIDTH(8), .N(4), .SEL_W(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .err_pulse(a_err), .drop_cnt(a_drop));

  stream_demux_n #(.WIDTH(8), .N(3), .SEL_W(2), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .err_pulse(b_err), .drop_cnt(b_drop));

  stream_demux_n #(.WIDTH(8), .N(4), .SEL_W(2), .MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_sel(c_in_sel), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .err_pulse(c_err), .drop_cnt(c_drop));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t exp;

  function automatic logic [7:0] lane(input logic [31:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0000", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", a_err); end
    checks++; if (b_drop !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", b_drop); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    checks++; if (c_out_valid !== 4'b0) begin errors++; $display("FAIL reset_rr_out_valid: got %b want 0000", c_out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic_routing;
    a_out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_sel = i[1:0]; a_in_data = 8'hA0 + 8'(i);
      sb.push_back('{i, 8'hA0 + 8'(i)});
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready beat %0d: got %b want 1", i, a_in_ready); end
      checks++; if (a_out_valid[i] !== 1'b0) begin errors++; $display("FAIL basic_latency beat %0d: out_valid early, got %b", i, a_out_valid); end
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++; if (a_out_valid !== 4'(1 << exp.ch)) begin errors++; $display("FAIL basic_out_valid beat %0d: got %b want %b", i, a_out_valid, 4'(1 << exp.ch)); end
      checks++; if (lane(a_out_data, exp.ch) !== exp.data) begin errors++; $display("FAIL basic_out_data ch %0d: got %h want %h", exp.ch, lane(a_out_data, exp.ch), exp.data); end
    end
    @(negedge clk) a_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL basic_drain: got %b want 0000", a_out_valid); end
  endtask

  task automatic test_backpressure;
    a_out_ready = 4'b1011;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h11; sb.push_back('{2, 8'h11});
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (a_out_valid[2] !== 1'b1 || lane(a_out_data, 2) !== exp.data) begin errors++; $display("FAIL bp_first_beat: valid %b data %h want 1 %h", a_out_valid[2], lane(a_out_data, 2), exp.data); end
    @(negedge clk);
    a_in_sel = 2'd1; a_in_data = 8'h33; sb.push_back('{1, 8'h33});
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_lane_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (a_out_valid[1] !== 1'b1 || lane(a_out_data, 1) !== exp.data) begin errors++; $display("FAIL bp_other_lane: valid %b data %h want 1 %h", a_out_valid[1], lane(a_out_data, 1), exp.data); end
    @(negedge clk);
    a_in_sel = 2'd2; a_in_data = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cycle %0d: got %b want 0", c, a_in_ready); end
      @(posedge clk); #1;
      checks++; if (a_out_valid[2] !== 1'b1 || lane(a_out_data, 2) !== 8'h11) begin errors++; $display("FAIL bp_hold cycle %0d: valid %b data %h want 1 11", c, a_out_valid[2], lane(a_out_data, 2)); end
      @(negedge clk);
    end
    a_out_ready = 4'hF; sb.push_back('{2, 8'h22});
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (a_out_valid !== 4'b0100 || lane(a_out_data, 2) !== exp.data) begin errors++; $display("FAIL bp_release_beat: valid %b data %h want 0100 %h", a_out_valid, lane(a_out_data, 2), exp.data); end
    @(negedge clk) a_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid[2] !== 1'b0 || lane(a_out_data, 2) !== 8'h22) begin errors++; $display("FAIL bp_data_hold: valid %b data %h want 0 22", a_out_valid[2], lane(a_out_data, 2)); end
  endtask

  task automatic test_full_throughput;
    a_out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h40 + 8'(i);
      sb.push_back('{0, 8'h40 + 8'(i)});
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL tput_ready beat %0d: got %b want 1", i, a_in_ready); end
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++; if (a_out_valid[0] !== 1'b1 || lane(a_out_data, 0) !== exp.data) begin errors++; $display("FAIL tput_beat %0d: valid %b data %h want 1 %h", i, a_out_valid[0], lane(a_out_data, 0), exp.data); end
    end
    @(negedge clk) a_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL tput_drain: got %b want 0000", a_out_valid); end
  endtask

  task automatic test_out_of_range;
    b_out_ready = 3'b111;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h55;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", b_in_ready); end
    @(posedge clk); #1;
    checks++; if (b_out_valid !== 3'b0) begin errors++; $display("FAIL oor_no_valid: got %b want 000", b_out_valid); end
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL oor_err_pulse: got %b want 1", b_err); end
    checks++; if (b_drop !== 8'd1) begin errors++; $display("FAIL oor_drop_cnt: got %0d want 1", b_drop); end
    @(negedge clk) b_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_err !== 1'b0 || b_drop !== 8'd1) begin errors++; $display("FAIL oor_pulse_width: err %b cnt %0d want 0 1", b_err, b_drop); end
    @(negedge clk);
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 8'h66;
    @(posedge clk); #1;
    checks++; if (b_out_valid !== 3'b100 || b_out_data[23:16] !== 8'h66 || b_err !== 1'b0) begin errors++; $display("FAIL oor_valid_lane: valid %b data %h err %b want 100 66 0", b_out_valid, b_out_data[23:16], b_err); end
    @(negedge clk);
    b_in_sel = 2'd3; b_in_data = 8'h77;
    repeat (299) @(posedge clk);
    #1;
    checks++; if (b_drop !== 8'd255) begin errors++; $display("FAIL oor_saturate: got %0d want 255", b_drop); end
    checks++; if (b_err !== 1'b1 || b_out_valid !== 3'b0) begin errors++; $display("FAIL oor_flood: err %b valid %b want 1 000", b_err, b_out_valid); end
    @(negedge clk) b_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_drop !== 8'd255 || b_err !== 1'b0) begin errors++; $display("FAIL oor_after: cnt %0d err %b want 255 0", b_drop, b_err); end
  endtask

  task automatic test_round_robin;
    logic [7:0] d;
    int         ch;
    c_out_ready = 4'hF;
    for (int i = 0; i < 10; i++) begin
      d = 8'(i + 1);
      ch = i % 4;
      @(negedge clk);
      if (i == 6) c_out_ready = 4'b1011;
      c_in_valid = 1'b1; c_in_data = d; c_in_sel = 2'($urandom);
      sb.push_back('{ch, d});
      #1;
      checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL rr_ready beat %0d: got %b want 1", i, c_in_ready); end
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++; if (c_out_valid[exp.ch] !== 1'b1 || lane(c_out_data, exp.ch) !== exp.data) begin errors++; $display("FAIL rr_beat %0d: ch %0d valid %b data %h want 1 %h", i, exp.ch, c_out_valid, lane(c_out_data, exp.ch), exp.data); end
    end
    @(negedge clk);
    c_in_data = 8'h0B; c_in_sel = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL rr_stall_ready cycle %0d: got %b want 0", c, c_in_ready); end
      @(posedge clk); #1;
      checks++; if (lane(c_out_data, 2) !== 8'h07 || c_out_valid[2] !== 1'b1) begin errors++; $display("FAIL rr_stall_hold cycle %0d: valid %b data %h want 1 07", c, c_out_valid[2], lane(c_out_data, 2)); end
      @(negedge clk);
    end
    c_out_ready = 4'hF; sb.push_back('{2, 8'h0B});
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL rr_release_ready: got %b want 1", c_in_ready); end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (c_out_valid !== 4'b0100 || lane(c_out_data, 2) !== exp.data) begin errors++; $display("FAIL rr_release_beat: valid %b data %h want 0100 %h", c_out_valid, lane(c_out_data, 2), exp.data); end
    @(negedge clk);
    c_in_data = 8'h0C; sb.push_back('{3, 8'h0C});
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (c_out_valid !== 4'b1000 || lane(c_out_data, 3) !== exp.data) begin errors++; $display("FAIL rr_no_skip: valid %b data %h want 1000 %h", c_out_valid, lane(c_out_data, 3), exp.data); end
    @(negedge clk) c_in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_stream;
    a_out_ready = 4'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h71;
    c_in_valid = 1'b1; c_in_data = 8'h0D;
    @(negedge clk);
    a_in_sel = 2'd1; a_in_data = 8'h72;
    c_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 4'b0011) begin errors++; $display("FAIL mid_prefill: got %b want 0011", a_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 4'b0 || a_out_data !== 32'h0) begin errors++; $display("FAIL mid_async_clear: valid %b data %h want 0000 0", a_out_valid, a_out_data); end
    checks++; if (c_out_valid !== 4'b0 || b_drop !== 8'd0) begin errors++; $display("FAIL mid_async_other: rr valid %b drop %0d want 0000 0", c_out_valid, b_drop); end
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 4'hF; c_out_ready = 4'hF;
    c_in_valid = 1'b1; c_in_data = 8'h0E; sb.push_back('{0, 8'h0E});
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++; if (c_out_valid !== 4'b0001 || lane(c_out_data, 0) !== exp.data) begin errors++; $display("FAIL mid_rr_ptr_reset: valid %b data %h want 0001 %h", c_out_valid, lane(c_out_data, 0), exp.data); end
    checks++; if (b_drop !== 8'd0) begin errors++; $display("FAIL mid_drop_after: got %0d want 0", b_drop); end
    @(negedge clk) c_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_sel = '0; c_out_ready = '1;
    #1;
    test_reset();
    test_basic_routing();
    test_backpressure();
    test_full_throughput();
    test_out_of_range();
    test_round_robin();
    test_reset_mid_stream();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
